// File: rtl/msg_ingress_arb.sv
// Packet-level round-robin arbiter: locks a winning Avalon-ST port from sop to eop and tags beats with the source port.
// Optional per-port accepted-packet counters are enabled with `define MSG_INGRESS_ARB_PKT_CNT_EN.
`timescale 1ns/1ps

module msg_ingress_arb #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned IN_WIDTH       = 64,
  parameter int unsigned IN_EMPTY_WIDTH = $clog2(IN_WIDTH/8),
  parameter int unsigned PORT_W         = $clog2(NUM_PORTS)
`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
  , parameter int unsigned CNT_WIDTH    = 16
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               in_valid,
  input  logic [NUM_PORTS-1:0]               in_startofpacket,
  input  logic [NUM_PORTS-1:0]               in_endofpacket,
  input  logic [NUM_PORTS*IN_WIDTH-1:0]      in_data,
  input  logic [NUM_PORTS*IN_EMPTY_WIDTH-1:0] in_empty,
  input  logic [NUM_PORTS-1:0]               in_error,
  output logic [NUM_PORTS-1:0]               in_ready,
  output logic                               out_valid,
  output logic                               out_startofpacket,
  output logic                               out_endofpacket,
  output logic [IN_WIDTH-1:0]                out_data,
  output logic [IN_EMPTY_WIDTH-1:0]          out_empty,
  output logic                               out_error,
  input  logic                               out_ready,
  output logic [PORT_W-1:0]                  out_port,
  output logic                               busy,
`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
  output logic [NUM_PORTS*CNT_WIDTH-1:0]     pkt_count,
`endif
  output logic                               stray_drop
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [PORT_W-1:0]        rr_q, rr_d;
  logic [PORT_W-1:0]        grant_q, grant_d;
  logic [PORT_W-1:0]        last_port_q;
  logic                     gap_q, gap_d;
  logic                     stray_q, stray_c;
  logic [NUM_PORTS-1:0]     req, stray_vec, ready_c;
  logic [PORT_W-1:0]        win, cand, sel, out_port_c;
  logic                     win_found, sel_valid, port_drive;
  logic                     sel_sop, sel_eop, sel_err;
  logic [IN_WIDTH-1:0]      sel_data;
  logic [IN_EMPTY_WIDTH-1:0] sel_empty;

  assign req       = in_valid & in_startofpacket;
  assign stray_vec = in_valid & ~in_startofpacket;

  // Round-robin search starting just after the last packet's port
  always_comb begin
    win       = rr_q;
    cand      = rr_q;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = PORT_W'((32'(rr_q) + i) % NUM_PORTS);
      if (!win_found && req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  assign sel = (state_q == LOCKED) ? grant_q : win;

  // Zero-latency beat mux
  always_comb begin
    sel_data  = '0;
    sel_empty = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_err   = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (sel == PORT_W'(p)) begin
        sel_data  = in_data[p*IN_WIDTH +: IN_WIDTH];
        sel_empty = in_empty[p*IN_EMPTY_WIDTH +: IN_EMPTY_WIDTH];
        sel_sop   = in_startofpacket[p];
        sel_eop   = in_endofpacket[p];
        sel_err   = in_error[p];
      end
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    gap_d      = 1'b0;
    ready_c    = '0;
    sel_valid  = 1'b0;
    stray_c    = 1'b0;
    port_drive = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = stray_vec;
        stray_c = |stray_vec;
        // gap_q blocks the grant for one cycle after a locked packet ends
        if (win_found && !gap_q) begin
          sel_valid    = 1'b1;
          port_drive   = 1'b1;
          ready_c[sel] = out_ready;
          if (out_ready) begin
            if (sel_eop) begin
              rr_d = sel;
            end else begin
              grant_d = sel;
              state_d = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        port_drive   = 1'b1;
        sel_valid    = in_valid[sel];
        ready_c[sel] = out_ready;
        if (sel_valid && out_ready && sel_eop) begin
          rr_d    = sel;
          state_d = IDLE;
          gap_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_port_c = port_drive ? sel : last_port_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= PORT_W'(NUM_PORTS - 1);
      grant_q     <= '0;
      gap_q       <= 1'b0;
      stray_q     <= 1'b0;
      last_port_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      gap_q       <= gap_d;
      stray_q     <= stray_c;
      last_port_q <= out_port_c;
    end
  end

  // Outputs are forced quiet while reset is held
  assign in_ready          = reset ? '0 : ready_c;
  assign out_valid         = sel_valid && !reset;
  assign out_startofpacket = sel_sop;
  assign out_endofpacket   = sel_eop;
  assign out_data          = sel_data;
  assign out_empty         = sel_empty;
  assign out_error         = sel_err;
  assign out_port          = reset ? '0 : out_port_c;
  assign busy              = (state_q == LOCKED) && !reset;
  assign stray_drop        = stray_q && !reset;

`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];

  // Saturating count of accepted eop beats per port
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (reset) begin
        cnt_q[p] <= '0;
      end else if (sel_valid && out_ready && sel_eop && (sel == PORT_W'(p)) && (cnt_q[p] != '1)) begin
        cnt_q[p] <= cnt_q[p] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_cnt_out
    assign pkt_count[gp*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gp];
  end
`endif

endmodule

// File: tb/tb_msg_ingress_arb.sv
// Self-checking bench for msg_ingress_arb: vector table, directed corner sequences and a random run against a reference model.
`timescale 1ns/1ps

module tb_msg_ingress_arb;
  localparam int unsigned NP = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned EW = 3;
  localparam int unsigned PW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     in_valid, in_startofpacket, in_endofpacket, in_error, in_ready;
  logic [NP*W-1:0]   in_data;
  logic [NP*EW-1:0]  in_empty;
  logic              out_valid, out_startofpacket, out_endofpacket, out_error, out_ready;
  logic [W-1:0]      out_data;
  logic [EW-1:0]     out_empty;
  logic [PW-1:0]     out_port;
  logic              busy, stray_drop;
`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
  logic [NP*16-1:0]  pkt_count;
`endif

  always #5 clk = ~clk;

  msg_ingress_arb #(.NUM_PORTS(NP), .IN_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_data(in_data), .in_empty(in_empty), .in_error(in_error), .in_ready(in_ready),
    .out_valid(out_valid), .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_data(out_data), .out_empty(out_empty), .out_error(out_error), .out_ready(out_ready),
    .out_port(out_port), .busy(busy),
`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
    .pkt_count(pkt_count),
`endif
    .stray_drop(stray_drop)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        err;
  } beat_t;

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] sop;
    logic [3:0] eop;
    logic       ordy;
    logic       ov;
    int         port;
    logic [3:0] rdy;
    logic       stray;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  beat_t srcq [NP][$];
  bit    holding [NP];
  int    ordy_pct = 100;
  int    present_pct = 100;
  bit    rand_mode = 1'b0;
  int    pkt_id = 0;

  // reference model state
  int    m_owner, m_rr, m_last;
  bit    m_gap, m_stray_prev;
  int    m_cnt [NP];
  logic [31:0] cur_tag;

  logic          tr_valid [$];
  int            tr_port [$];
  logic          tr_busy [$];
  logic [NP-1:0] tr_ready [$];
  logic          tr_stray [$];
  logic [63:0]   tr_data [$];
  int            sop_order [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int port, input int n, input bit stray);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = {8'(port), 24'(pkt_id), 16'(i), 16'($urandom)};
      b.sop   = (i == 0) && !stray;
      b.eop   = (i == n - 1);
      b.empty = b.eop ? 3'($urandom_range(7)) : 3'd0;
      b.err   = b.eop && ($urandom_range(7) == 0);
      srcq[port].push_back(b);
    end
    pkt_id++;
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      if (!holding[p] && srcq[p].size() > 0 && $urandom_range(99) < present_pct) holding[p] = 1'b1;
      if (holding[p]) begin
        b = srcq[p][0];
        in_valid[p] = 1'b1;
        in_startofpacket[p] = b.sop;
        in_endofpacket[p] = b.eop;
        in_data[p*W +: W] = b.data;
        in_empty[p*EW +: EW] = b.empty;
        in_error[p] = b.err;
      end else begin
        in_valid[p] = 1'b0;
        in_startofpacket[p] = 1'b0;
        in_endofpacket[p] = 1'b0;
        in_data[p*W +: W] = {$urandom, $urandom};
        in_empty[p*EW +: EW] = '0;
        in_error[p] = 1'b0;
      end
    end
  endtask

  task automatic clear_trace();
    tr_valid.delete(); tr_port.delete(); tr_busy.delete();
    tr_ready.delete(); tr_stray.delete(); tr_data.delete(); sop_order.delete();
  endtask

  task automatic apply_reset(input bit check);
    reset = 1'b1;
    drive_inputs();
    out_ready = 1'b1;
    #4;
    if (check) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stray", 64'(stray_drop), 64'd0);
      chk("rst_out_port", 64'(out_port), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int p = 0; p < NP; p++) begin
      srcq[p].delete();
      holding[p] = 1'b0;
      m_cnt[p] = 0;
    end
    m_owner = -1; m_rr = NP - 1; m_last = 0; m_gap = 1'b0; m_stray_prev = 1'b0;
    drive_inputs();
`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
    if (check) chk("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
    clear_trace();
  endtask

  // One clock: drive, check against model at mid-cycle, then advance sources and model
  task automatic step();
    beat_t b;
    logic [NP-1:0] er, samp_ready;
    logic ev;
    bit es, acc;
    int w, ep, n_owner, n_rr;
    bit n_gap;
    b = '0;
    if (rand_mode) begin
      for (int p = 0; p < NP; p++)
        if (srcq[p].size() == 0 && !holding[p]) begin
          if ($urandom_range(9) == 0) push_pkt(p, 1, 1'b1);
          else push_pkt(p, int'($urandom_range(1, 4)), 1'b0);
        end
    end
    drive_inputs();
    out_ready = ($urandom_range(99) < ordy_pct);
    #4;
    er = '0; ev = 1'b0; ep = m_last; es = 1'b0; w = -1;
    if (m_owner < 0) begin
      for (int q = 0; q < NP; q++)
        if (in_valid[q] && !in_startofpacket[q]) begin er[q] = 1'b1; es = 1'b1; end
      if (!m_gap)
        for (int k = 1; k <= NP; k++) begin
          int c;
          c = (m_rr + k) % NP;
          if (w < 0 && in_valid[c] && in_startofpacket[c]) w = c;
        end
      if (w >= 0) begin ev = 1'b1; ep = w; er[w] = out_ready; end
    end else begin
      w = m_owner; ev = in_valid[w]; ep = w; er[w] = out_ready;
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    chk("stray_drop", 64'(stray_drop), 64'(m_stray_prev));
    chk("out_port", 64'(out_port), 64'(ep));
    if (ev) begin
      b = srcq[w][0];
      chk("out_data", out_data, b.data);
      chk("out_ctl", 64'({out_startofpacket, out_endofpacket, out_empty, out_error}),
          64'({b.sop, b.eop, b.empty, b.err}));
    end
    acc = ev && out_ready;
    n_owner = m_owner; n_rr = m_rr; n_gap = 1'b0;
    if (acc) begin
      if (b.sop) begin
        cur_tag = b.data[63:32];
        sop_order.push_back(int'(out_port));
      end else begin
        chk("pkt_contig", 64'(out_data[63:32]), 64'(cur_tag));
      end
      if (m_owner < 0) begin
        if (b.eop) begin n_rr = w; m_cnt[w]++; end
        else n_owner = w;
      end else if (b.eop) begin
        n_rr = w; n_owner = -1; n_gap = 1'b1; m_cnt[w]++;
      end
    end
    tr_valid.push_back(out_valid); tr_port.push_back(int'(out_port)); tr_busy.push_back(busy);
    tr_ready.push_back(in_ready); tr_stray.push_back(stray_drop); tr_data.push_back(out_data);
    samp_ready = in_ready;
    @(posedge clk); #1;
    m_owner = n_owner; m_rr = n_rr; m_gap = n_gap; m_stray_prev = es; m_last = ep;
    for (int p = 0; p < NP; p++)
      if (in_valid[p] && samp_ready[p]) begin
        void'(srcq[p].pop_front());
        holding[p] = 1'b0;
      end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vec_t tbl [12];
    logic [63:0] held;
    int exp_v [8], exp_p [8], exp_b [8], guard;

    // arbitration vectors applied back-to-back from reset (rr_ptr starts at 3)
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b1, 1, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 3, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0101, 4'b0001, 4'b0000, 1'b0, 1'b1, 0, 4'b0100, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2, 4'b0100, 1'b0};
    tbl[6]  = '{4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1, 0, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1101, 4'b1101, 4'b0000, 1'b0, 1'b1, 3, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 3, 4'b0010, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3, 4'b0000, 1'b1};
    tbl[10] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 0, 4'b0001, 1'b0};
    tbl[11] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1, 4'b0000, 1'b0};

    in_valid = '0; in_startofpacket = '0; in_endofpacket = '0; in_error = '0;
    in_data = '0; in_empty = '0; out_ready = 1'b0;
    for (int p = 0; p < NP; p++) holding[p] = 1'b0;
    @(posedge clk); #1;
    apply_reset(1'b1);

    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v; in_startofpacket = tbl[i].sop; in_endofpacket = tbl[i].eop;
      out_ready = tbl[i].ordy; in_empty = '0; in_error = '0;
      for (int p = 0; p < NP; p++) in_data[p*W +: W] = 64'hC0DE_0000_0000_0000 | 64'(p);
      #4;
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_port", i), 64'(out_port), 64'(tbl[i].port));
      chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'd0);
      chk($sformatf("tbl%0d_stray", i), 64'(stray_drop), 64'(tbl[i].stray));
      if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), out_data, 64'hC0DE_0000_0000_0000 | 64'(tbl[i].port));
      @(posedge clk); #1;
    end

    // ports 0 and 2 with 3-beat packets: 0 on cycles 0-2, gap, 2 on cycles 4-6
    apply_reset(1'b1);
    push_pkt(0, 3, 1'b0); push_pkt(2, 3, 1'b0);
    run(8);
    exp_v = '{1, 1, 1, 0, 1, 1, 1, 0};
    exp_p = '{0, 0, 0, 0, 2, 2, 2, 2};
    exp_b = '{0, 1, 1, 0, 0, 1, 1, 0};
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("seqA_valid%0d", c), 64'(tr_valid[c]), 64'(exp_v[c]));
      chk($sformatf("seqA_port%0d", c), 64'(tr_port[c]), 64'(exp_p[c]));
      chk($sformatf("seqA_busy%0d", c), 64'(tr_busy[c]), 64'(exp_b[c]));
    end

    // all ports, 4 x 2-beat packets each: strict rotation
    apply_reset(1'b1);
    for (int k = 0; k < 4; k++) for (int p = 0; p < NP; p++) push_pkt(p, 2, 1'b0);
    guard = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()) > 0 && guard < 80) begin
      step(); guard++;
    end
    chk("seqB_done_in_budget", 64'(guard < 80), 64'd1);
    chk("seqB_pkt_cnt", 64'(sop_order.size()), 64'd16);
    for (int i = 0; i < sop_order.size() && i < 16; i++)
      chk($sformatf("seqB_order%0d", i), 64'(sop_order[i]), 64'(i % NP));

    // port 1 locked, port 3 waits until after eop and the gap cycle
    apply_reset(1'b1);
    push_pkt(1, 4, 1'b0); push_pkt(3, 2, 1'b0);
    run(8);
    for (int c = 0; c < 5; c++) chk($sformatf("seqC_rdy3_%0d", c), 64'(tr_ready[c][3]), 64'd0);
    chk("seqC_port1_c3", 64'(tr_port[3]), 64'd1);
    chk("seqC_gap_valid", 64'(tr_valid[4]), 64'd0);
    chk("seqC_grant3_valid", 64'(tr_valid[5]), 64'd1);
    chk("seqC_grant3_port", 64'(tr_port[5]), 64'd3);

    // single-beat packet from port 2, then rotation moves to port 0
    apply_reset(1'b1);
    push_pkt(2, 1, 1'b0);
    run(1);
    push_pkt(2, 1, 1'b0); push_pkt(0, 2, 1'b0);
    run(3);
    chk("seqD_first_port", 64'(tr_port[0]), 64'd2);
    chk("seqD_no_lock", 64'(tr_busy[1]), 64'd0);
    chk("seqD_next_valid", 64'(tr_valid[1]), 64'd1);
    chk("seqD_next_port", 64'(tr_port[1]), 64'd0);
    chk("seqD_locked0", 64'(tr_busy[2]), 64'd1);

    // stray beat on port 0 while idle
    apply_reset(1'b1);
    push_pkt(0, 1, 1'b1);
    run(2);
    chk("seqE_valid", 64'(tr_valid[0]), 64'd0);
    chk("seqE_ready0", 64'(tr_ready[0][0]), 64'd1);
    chk("seqE_stray_now", 64'(tr_stray[0]), 64'd0);
    chk("seqE_stray_next", 64'(tr_stray[1]), 64'd1);
`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
    chk("seqE_count0", 64'(pkt_count[15:0]), 64'd0);
`endif

    // stall mid-packet, then reset
    apply_reset(1'b1);
    push_pkt(1, 4, 1'b0);
    run(2);
    held = srcq[1][0].data;
    ordy_pct = 0;
    run(5);
    for (int c = 2; c < 7; c++) begin
      chk($sformatf("seqF_valid%0d", c), 64'(tr_valid[c]), 64'd1);
      chk($sformatf("seqF_data%0d", c), tr_data[c], held);
    end
    ordy_pct = 100;
    apply_reset(1'b1);
    push_pkt(3, 1, 1'b0); push_pkt(0, 1, 1'b0); push_pkt(1, 1, 1'b0);
    run(2);
    chk("seqF_after_port", 64'(tr_port[0]), 64'd0);
    chk("seqF_after_busy", 64'(tr_busy[0]), 64'd0);
    chk("seqF_after_stray", 64'(tr_stray[0]), 64'd0);

    // random traffic against the reference model
    apply_reset(1'b1);
    ordy_pct = 75; present_pct = 70; rand_mode = 1'b1;
    run(3000);
`ifdef MSG_INGRESS_ARB_PKT_CNT_EN
    for (int p = 0; p < NP; p++)
      chk($sformatf("rand_count%0d", p), 64'(pkt_count[p*16 +: 16]), 64'(m_cnt[p]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
